// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter fed by a small write-side FIFO. Each queued word is sent LSB-first as a
// start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits. Every bit is
// held for CLKS_PER_BIT clocks. Queued words follow each other with no idle gap.
//
// Ports:
//   clock_50_b7a  in   system clock, all logic on the rising edge
//   reset         in   asynchronous active-low reset (deassertion synchronised internally)
//   wr_data       in   word to enqueue
//   wr_en         in   enqueue request, accepted when the FIFO is not full
//   tx            out  registered serial line, idle high
//   busy          out  high while a frame is on the line
//   full          out  FIFO holds FIFO_DEPTH words
//   empty         out  FIFO holds no words
//   level         out  current FIFO occupancy
//   overflow      out  one-cycle pulse after a write was dropped because the FIFO was full

module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clock_50_b7a,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_en,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int unsigned     AddrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [AddrW:0]  PtrOne   = (AddrW + 1)'(1);
    localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // Reset asserts asynchronously but releases two edges later, so a write on the
    // release edge is never seen by the pointers.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock_50_b7a or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // FIFO storage and pointers (one bit wider than the index to tell full from empty).
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AddrW:0]       wptr_q, rptr_q;
    logic                 push, pop;
    logic                 overflow_q;
    logic [DATA_BITS-1:0] head;

    assign full     = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                      (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign empty    = (wptr_q == rptr_q);
    assign level    = wptr_q - rptr_q;
    assign push     = wr_en && !full;
    assign head     = mem_q[rptr_q[AddrW-1:0]];
    assign overflow = overflow_q;

    always_ff @(posedge clock_50_b7a) begin
        if (push) begin
            mem_q[wptr_q[AddrW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock_50_b7a or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
            // Uses the pre-edge full flag: a pop on the same edge does not rescue the write.
            overflow_q <= wr_en && full;
        end
    end

    // Transmit FSM.
    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 start_frame;

    assign bit_end = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        pop         = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = cnt_q - CntOne;
        end

        unique case (state_q)
            StIdle: begin
                tx_d  = 1'b1;
                cnt_d = CntMax;
                if (!empty) begin
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = CntMax;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = CntMax;
                    if (bit_q == LastData) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    cnt_d   = CntMax;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = CntMax;
                    if (bit_q == LastStop) begin
                        // Chain straight into the next start bit when a word is waiting.
                        if (!empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            pop     = 1'b1;
            state_d = StStart;
            cnt_d   = CntMax;
            bit_d   = '0;
            tx_d    = 1'b0;
            shift_d = head;
            // Odd parity inverts the XOR so the frame carries an odd count of ones.
            par_d   = (PARITY == 1) ? ~^head : ^head;
        end
    end

    always_ff @(posedge clock_50_b7a or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: default instance checked by a serial-line scoreboard plus directed
// sequences; three extra instances cover parity and the 7-bit / 2-stop frame format.

module tb_uart_tx_fifo;

    localparam int Cpb = 16;

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic       acc;
        logic [2:0] lvl;
        logic       fl;
        logic       em;
        logic       ov;
        logic       bz;
    } burst_vec_t;

    typedef struct {
        int         k;
        logic [8:0] word;
        int         db;
        int         par;
        int         sb;
        int         len;
        int         par_idx;
        int         par_bit;
        int         lows;
    } aux_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en0, wr_en1, wr_en2, wr_en3;
    logic [7:0] wr_data0, wr_data1, wr_data2;
    logic [6:0] wr_data3;
    logic       tx0, tx1, tx2, tx3;
    logic       busy0, busy1, busy2, busy3;
    logic       full0, full1, full2, full3;
    logic       empty0, empty1, empty2, empty3;
    logic [2:0] level0, level1, level2, level3;
    logic       overflow0, overflow1, overflow2, overflow3;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         frames_done = 0;
    logic       mon_en = 1'b1;
    logic [7:0] exp_q[$];
    int         starts[$];
    burst_vec_t bv[7];
    aux_vec_t   av[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo dut0 (
        .clock_50_b7a(clk), .reset(reset), .wr_data(wr_data0), .wr_en(wr_en0), .tx(tx0),
        .busy(busy0), .full(full0), .empty(empty0), .level(level0), .overflow(overflow0)
    );
    uart_tx_fifo #(.PARITY(2)) dut1 (
        .clock_50_b7a(clk), .reset(reset), .wr_data(wr_data1), .wr_en(wr_en1), .tx(tx1),
        .busy(busy1), .full(full1), .empty(empty1), .level(level1), .overflow(overflow1)
    );
    uart_tx_fifo #(.PARITY(1)) dut2 (
        .clock_50_b7a(clk), .reset(reset), .wr_data(wr_data2), .wr_en(wr_en2), .tx(tx2),
        .busy(busy2), .full(full2), .empty(empty2), .level(level2), .overflow(overflow2)
    );
    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) dut3 (
        .clock_50_b7a(clk), .reset(reset), .wr_data(wr_data3), .wr_en(wr_en3), .tx(tx3),
        .busy(busy3), .full(full3), .empty(empty3), .level(level3), .overflow(overflow3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Expected line levels of one frame, one entry per bit period.
    function automatic void build_wave(input logic [8:0] w, input int db, input int par,
                                       input int sb, output logic [15:0] bits, output int nb);
        logic p;
        bits = '1;
        nb = 0;
        p = 1'b0;
        bits[nb] = 1'b0;
        nb++;
        for (int i = 0; i < db; i++) begin
            bits[nb] = w[i];
            p = p ^ w[i];
            nb++;
        end
        if (par == 1) begin
            bits[nb] = ~p;
            nb++;
        end else if (par == 2) begin
            bits[nb] = p;
            nb++;
        end
        for (int i = 0; i < sb; i++) begin
            bits[nb] = 1'b1;
            nb++;
        end
    endfunction

    // Scoreboard side: checks a whole frame of dut0 cycle by cycle against the queued word.
    task automatic check_frame();
        logic [7:0]  w;
        logic [15:0] bits;
        int          nb;
        int          first_bad;
        starts.push_back(cyc);
        check("frame_queued", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) begin
            for (int c = 1; c < 10 * Cpb; c++) begin
                @(negedge clk);
                if (!mon_en) return;
            end
            return;
        end
        w = exp_q.pop_front();
        build_wave({1'b0, w}, 8, 0, 1, bits, nb);
        first_bad = -1;
        for (int c = 0; c < nb * Cpb; c++) begin
            if (c > 0) @(negedge clk);
            if (!mon_en) return;
            if (first_bad < 0 && (tx0 !== bits[c / Cpb] || busy0 !== 1'b1)) first_bad = c;
        end
        check($sformatf("frame_%02h_first_bad_cycle", w), 32'(first_bad), 32'hffff_ffff);
        frames_done++;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en && tx0 === 1'b0) check_frame();
        end
    end

    task automatic busy_run(output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int g;
        g = 0;
        while (frames_done < target && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("frame_timeout", 32'(frames_done >= target), 32'd1);
    endtask

    function automatic logic aux_tx(input int k);
        case (k)
            1: return tx1;
            2: return tx2;
            default: return tx3;
        endcase
    endfunction

    function automatic logic aux_busy(input int k);
        case (k)
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    task automatic aux_write(input int k, input logic [8:0] w);
        case (k)
            1: begin wr_en1 = 1'b1; wr_data1 = w[7:0]; end
            2: begin wr_en2 = 1'b1; wr_data2 = w[7:0]; end
            default: begin wr_en3 = 1'b1; wr_data3 = w[6:0]; end
        endcase
        @(negedge clk);
        wr_en1 = 1'b0;
        wr_en2 = 1'b0;
        wr_en3 = 1'b0;
    endtask

    task automatic capture(input int k, output int len, output logic [511:0] wave);
        int guard;
        wave = '1;
        len = 0;
        guard = 0;
        while (aux_busy(k) !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        while (aux_busy(k) === 1'b1 && len < 512) begin
            wave[len] = aux_tx(k);
            len++;
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got=time_limit want=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        int           n, f0, f1, lows, base, gap, len, first_bad;
        logic [511:0] wave;
        logic [15:0]  bits;
        int           nb;

        bv[0] = '{1'b1, 8'hA1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        bv[1] = '{1'b1, 8'hB2, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        bv[2] = '{1'b1, 8'hC3, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        bv[3] = '{1'b1, 8'hD4, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        bv[4] = '{1'b1, 8'hE5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
        bv[5] = '{1'b1, 8'hF6, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
        bv[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};

        av[0] = '{1, 9'h007, 8, 2, 1, 176, 9 * Cpb + 8, 1, 6 * Cpb};
        av[1] = '{2, 9'h007, 8, 1, 1, 176, 9 * Cpb + 8, 0, 7 * Cpb};
        av[2] = '{3, 9'h07F, 7, 0, 2, 160, -1, 0, Cpb};

        reset = 1'b0;
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0; wr_en3 = 1'b0;
        wr_data0 = '0; wr_data1 = '0; wr_data2 = '0; wr_data3 = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_tx", 32'(tx0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_full", 32'(full0), 32'd0);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_level", 32'(level0), 32'd0);
        check("rst_overflow", 32'(overflow0), 32'd0);
        check("rst_aux_tx", 32'({tx1, tx2, tx3}), 32'h7);
        check("rst_aux_flags", 32'({busy1, busy2, busy3, full1, full2, full3, overflow1,
                                     overflow2, overflow3, |level1, |level2, |level3}), 32'd0);
        check("rst_aux_empty", 32'({empty1, empty2, empty3}), 32'h7);

        // A write held across reset release is ignored.
        wr_en0 = 1'b1;
        wr_data0 = 8'h3C;
        reset = 1'b1;
        @(negedge clk);
        wr_en0 = 1'b0;
        repeat (3) @(negedge clk);
        check("release_write_level", 32'(level0), 32'd0);
        check("release_write_empty", 32'(empty0), 32'd1);

        // Single word 0xA5: latency and busy length.
        wr_en0 = 1'b1;
        wr_data0 = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en0 = 1'b0;
        check("lat_level", 32'(level0), 32'd1);
        check("lat_busy", 32'(busy0), 32'd0);
        check("lat_tx_idle", 32'(tx0), 32'd1);
        @(negedge clk);
        check("lat_tx_start", 32'(tx0), 32'd0);
        check("lat_level_pop", 32'(level0), 32'd0);
        busy_run(n);
        check("a5_busy_cycles", 32'(n), 32'd160);
        check("a5_tx_after", 32'(tx0), 32'd1);
        check("a5_frames", 32'(frames_done), 32'd1);

        // Back-to-back 0x55 then 0xAA.
        base = starts.size();
        wr_en0 = 1'b1;
        wr_data0 = 8'h55;
        exp_q.push_back(8'h55);
        @(negedge clk);
        wr_data0 = 8'hAA;
        exp_q.push_back(8'hAA);
        @(negedge clk);
        wr_en0 = 1'b0;
        busy_run(n);
        check("b2b_busy_cycles", 32'(n), 32'd320);
        gap = (starts.size() >= base + 2) ? starts[base + 1] - starts[base] : -1;
        check("b2b_start_gap", 32'(gap), 32'd160);
        check("b2b_frames", 32'(frames_done), 32'd3);

        // Burst of six writes into a depth-4 FIFO.
        f0 = frames_done;
        for (int i = 0; i < 7; i++) begin
            wr_en0 = bv[i].en;
            wr_data0 = bv[i].data;
            if (bv[i].en && bv[i].acc) exp_q.push_back(bv[i].data);
            @(negedge clk);
            check($sformatf("burst%0d_level", i), 32'(level0), 32'(bv[i].lvl));
            check($sformatf("burst%0d_full", i), 32'(full0), 32'(bv[i].fl));
            check($sformatf("burst%0d_empty", i), 32'(empty0), 32'(bv[i].em));
            check($sformatf("burst%0d_overflow", i), 32'(overflow0), 32'(bv[i].ov));
            check($sformatf("burst%0d_busy", i), 32'(busy0), 32'(bv[i].bz));
        end
        wr_en0 = 1'b0;
        busy_run(n);
        repeat (40) @(negedge clk);
        check("burst_frames", 32'(frames_done - f0), 32'd5);
        check("burst_queue_left", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the second queued frame.
        f0 = frames_done;
        foreach (bv[i]) if (i < 3) begin
            wr_en0 = 1'b1;
            wr_data0 = 8'h11 * 8'(i + 1);
            exp_q.push_back(8'h11 * 8'(i + 1));
            @(negedge clk);
        end
        wr_en0 = 1'b0;
        wait_frames(f0 + 1, 400);
        repeat (3 * Cpb + 5) @(negedge clk);
        check("mid_busy_before", 32'(busy0), 32'd1);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx0), 32'd1);
        check("mid_rst_empty", 32'(empty0), 32'd1);
        check("mid_rst_level", 32'(level0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        f1 = frames_done;
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
        end
        check("post_rst_tx_low", 32'(lows), 32'd0);
        check("post_rst_frames", 32'(frames_done), 32'(f1));
        check("post_rst_level", 32'(level0), 32'd0);

        // Parity and frame-format instances.
        for (int i = 0; i < 3; i++) begin
            aux_write(av[i].k, av[i].word);
            capture(av[i].k, len, wave);
            build_wave(av[i].word, av[i].db, av[i].par, av[i].sb, bits, nb);
            first_bad = -1;
            lows = 0;
            for (int c = 0; c < len; c++) begin
                if (first_bad < 0 && (c >= nb * Cpb || wave[c] !== bits[c / Cpb])) first_bad = c;
                if (wave[c] === 1'b0) lows++;
            end
            check($sformatf("aux%0d_len", av[i].k), 32'(len), 32'(av[i].len));
            check($sformatf("aux%0d_first_bad", av[i].k), 32'(first_bad), 32'hffff_ffff);
            check($sformatf("aux%0d_low_cycles", av[i].k), 32'(lows), 32'(av[i].lows));
            if (av[i].par_idx >= 0) begin
                check($sformatf("aux%0d_parity_bit", av[i].k), 32'(wave[av[i].par_idx]),
                      32'(av[i].par_bit));
            end
            check($sformatf("aux%0d_tx_after", av[i].k), 32'(aux_tx(av[i].k)), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
